layer_output_packer: RTL and testbench
======================================

// Module: layer_output_packer
// PURPOSE
//  Collects the NN_lyr final-layer neuron outputs, which finish at independent times,
//  into one packed vector. Emits that vector with a one-cycle valid strobe to the
//  argmax/prediction stage.
//  Sits between the output-layer neurons and the max-finder. Its outData/outValid pair
//  drives the max-finder's inputData/inputValidity directly.
//  Also detects incomplete and duplicate-output frames.
// PARAMETERS
//  NN_lyr     10    number of output neurons (lanes); lane i = outData[i*dataWidth+:dataWidth]
//  dataWidth  16    width of one neuron output, passed through unmodified
//  TIMEOUT    1024  max cycles a partial frame may wait for missing lanes; must be >= 2
// PORTS
//  clk          in   1                  clock, rising edge
//  rst          in   1                  asynchronous, active-low reset
//  neuronValid  in   NN_lyr             per-lane one-cycle strobe: neuronData lane i valid
//  neuronData   in   NN_lyr*dataWidth   packed neuron outputs, lane i sampled only when neuronValid[i]=1
//  outValid     out  1                  one-cycle strobe: outData holds a complete frame
//  outData      out  NN_lyr*dataWidth   packed frame; held stable until the next outValid
//  capturedMask out  NN_lyr             lanes captured so far in the current frame
//  errDup       out  1                  one-cycle pulse: a lane strobed twice in one frame
//  errTimeout   out  1                  one-cycle pulse: partial frame abandoned
//  busy         out  1                  1 while state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; outValid=0, outData=0, capturedMask=0, errDup=0,
//   errTimeout=0, timer=0. Internal capture registers cleared.
//   Reset mid-frame discards the partial frame; no outValid and no error are produced.
//  Internal storage:
//   - capture register per lane (dataWidth bits)
//   - captured mask (NN_lyr bits)
//   - timer, width clog2(TIMEOUT)
//  States:
//   IDLE:
//    - Lanes with neuronValid=1 are captured and their mask bits set; timer cleared.
//    - If the resulting mask is all-ones (all lanes in one cycle) -> EMIT.
//    - Else, if any lane was captured -> COLLECT.
//    - Else stay in IDLE.
//   COLLECT:
//    - Lanes with neuronValid=1 and mask=0 are captured.
//    - Lanes with neuronValid=1 and mask=1 are ignored, keeping the first value, and
//      errDup pulses next cycle. A single pulse covers any number of such lanes that cycle.
//    - Completion: mask | new lanes == all-ones -> EMIT.
//    - Else, if timer == TIMEOUT-1 -> errTimeout pulses next cycle, mask and timer cleared,
//      state -> IDLE. Lanes strobed in that same cycle are also discarded.
//    - Else timer increments.
//    - Completion takes priority over timeout when both occur in the same cycle.
//   EMIT (exactly one cycle):
//    - outValid=1 and outData = capture registers. outData is registered on the edge that
//      enters EMIT, so it is valid during the outValid cycle.
//    - Mask is cleared at the end of EMIT.
//    - neuronValid lanes seen during EMIT start the next frame: they are captured into a
//      fresh mask, using IDLE rules, and the next state is EMIT/COLLECT/IDLE accordingly.
//      They are never flagged as duplicates.
//  Latency: last missing lane strobed in cycle N -> outValid=1 in cycle N+1.
//   Peak throughput: one frame per cycle when all lanes strobe together every cycle.
//  outData changes only on entry to EMIT. Between frames it holds the last frame.
//  capturedMask reflects registered mask state: updated the cycle after a strobe, 0 in IDLE.
//  No backpressure: the consumer must accept every outValid pulse.
//  Data is passed bit-exact; no arithmetic is performed on lanes.
// TESTING
//  T1 in-order fill:
//   - Stimulus: lanes 0..9 strobed one per cycle, data = 16'h0100+i.
//   - Response: outValid exactly once, in the cycle after lane 9; outData lane i = 16'h0100+i;
//     busy back to 0.
//  T2 all-at-once:
//   - Stimulus: neuronValid=10'h3FF for 3 consecutive cycles with distinct data each cycle.
//   - Response: 3 back-to-back outValid pulses, each with the matching data; no errDup.
//  T3 duplicate:
//   - Stimulus: lane 4 strobed with 16'hAAAA, then again with 16'hBBBB, then the remaining lanes.
//   - Response: errDup pulses once; emitted lane 4 = 16'hAAAA.
//  T4 timeout (TIMEOUT=16):
//   - Stimulus: only lanes 0..8 strobed, then idle.
//   - Response: errTimeout pulses 16 cycles after the first capture; no outValid; capturedMask=0.
//   - Follow-up: a full frame afterwards emits normally.
//  T5 reset mid-frame:
//   - Stimulus: 5 lanes captured, rst pulsed low for a partial cycle.
//   - Response: outputs go to 0 immediately; no error pulses; next full frame emits correctly.
//  T6 completion at timeout edge:
//   - Stimulus: last lane strobed exactly when timer == TIMEOUT-1.
//   - Response: outValid=1; errTimeout stays 0.

Source files
------------

// File: rtl/layer_output_packer.sv
// Gathers output-layer neuron results that finish at different times into one packed
// frame, strobes it to the max-finder, and flags duplicate lanes and abandoned frames.
module layer_output_packer #(
  parameter int unsigned NN_lyr    = 10,
  parameter int unsigned dataWidth = 16,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NN_lyr-1:0]           neuronValid,
  input  logic [NN_lyr*dataWidth-1:0] neuronData,
  output logic                        outValid,
  output logic [NN_lyr*dataWidth-1:0] outData,
  output logic [NN_lyr-1:0]           capturedMask,
  output logic                        errDup,
  output logic                        errTimeout,
  output logic                        busy
);

  localparam int unsigned timerWidth = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned busWidth   = NN_lyr * dataWidth;

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} stateT;

  stateT                 state, stateNext;
  logic [NN_lyr-1:0]     mask, maskNext;
  logic [NN_lyr-1:0]     captureEn;
  logic [NN_lyr-1:0]     newLanes;
  logic [timerWidth-1:0] timer, timerNext;
  logic [busWidth-1:0]   capReg, capNext;
  logic                  dupNext, timeoutNext;

  assign newLanes     = neuronValid & ~mask;
  assign capturedMask = mask;

  // Next-state, mask, timer and capture-enable decisions
  always_comb begin
    stateNext   = state;
    maskNext    = mask;
    timerNext   = timer;
    captureEn   = '0;
    dupNext     = 1'b0;
    timeoutNext = 1'b0;
    unique case (state)
      IDLE, EMIT: begin
        // EMIT's strobes open a fresh frame, never counted as duplicates
        captureEn = neuronValid;
        maskNext  = neuronValid;
        timerNext = '0;
        if (&neuronValid)      stateNext = EMIT;
        else if (|neuronValid) stateNext = COLLECT;
        else                   stateNext = IDLE;
      end
      COLLECT: begin
        dupNext = |(neuronValid & mask);
        if (&(mask | newLanes)) begin
          captureEn = newLanes;
          maskNext  = '1;
          stateNext = EMIT;
        end else if (timer == timerWidth'(TIMEOUT - 1)) begin
          timeoutNext = 1'b1;
          maskNext    = '0;
          timerNext   = '0;
          stateNext   = IDLE;
        end else begin
          captureEn = newLanes;
          maskNext  = mask | newLanes;
          timerNext = timer + timerWidth'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Merge newly strobed lanes over the held captures
  always_comb begin
    capNext = capReg;
    for (int i = 0; i < int'(NN_lyr); i++) begin
      if (captureEn[i]) capNext[i*dataWidth +: dataWidth] = neuronData[i*dataWidth +: dataWidth];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mask       <= '0;
      timer      <= '0;
      capReg     <= '0;
      outValid   <= 1'b0;
      outData    <= '0;
      errDup     <= 1'b0;
      errTimeout <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= stateNext;
      mask       <= maskNext;
      timer      <= timerNext;
      capReg     <= capNext;
      outValid   <= (stateNext == EMIT);
      errDup     <= dupNext;
      errTimeout <= timeoutNext;
      busy       <= (stateNext != IDLE);
      if (stateNext == EMIT) outData <= capNext;
    end
  end

endmodule

// File: tb/tb_layer_output_packer.sv
// Bench for layer_output_packer: directed scenarios plus random lane strobes, checked
// every cycle against a frame-level model of the packer.
module tb_layer_output_packer;

  localparam int NN = 10;
  localparam int DW = 16;
  localparam int TO = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NN-1:0]       neuronValid = '0;
  logic [NN*DW-1:0]    neuronData = '0;
  logic                outValid;
  logic [NN*DW-1:0]    outData;
  logic [NN-1:0]       capturedMask;
  logic                errDup;
  logic                errTimeout;
  logic                busy;

  layer_output_packer #(.NN_lyr(NN), .dataWidth(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .neuronValid(neuronValid), .neuronData(neuronData),
    .outValid(outValid), .outData(outData), .capturedMask(capturedMask),
    .errDup(errDup), .errTimeout(errTimeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Frame-level model: which lanes the open frame holds, their values, and its age
  bit            mCollecting, mEmitting, mDup, mTo;
  bit [NN-1:0]   mMask;
  logic [DW-1:0] mLane [NN];
  int            mAge;
  logic [NN*DW-1:0] mOut;
  int            dupPulses, toPulses, validPulses;

  task automatic check(input string name, input logic [NN*DW-1:0] act, input logic [NN*DW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mCollecting = 0; mEmitting = 0; mDup = 0; mTo = 0; mMask = '0; mAge = 0; mOut = '0;
    for (int i = 0; i < NN; i++) mLane[i] = '0;
  endtask

  task automatic modelStep(input logic [NN-1:0] v, input logic [NN*DW-1:0] d);
    bit [NN-1:0] full;
    full = '1;
    mDup = 0; mTo = 0;
    if (!mCollecting) begin
      mMask = v;
      mAge  = 0;
      for (int i = 0; i < NN; i++) if (v[i]) mLane[i] = d[i*DW +: DW];
      mEmitting   = (v == full);
      mCollecting = !mEmitting && (v != 0);
    end else begin
      mDup = ((v & mMask) != 0);
      if ((mMask | v) == full) begin
        for (int i = 0; i < NN; i++) if (v[i] && !mMask[i]) mLane[i] = d[i*DW +: DW];
        mMask = full; mEmitting = 1; mCollecting = 0;
      end else if (mAge == TO - 1) begin
        mTo = 1; mMask = '0; mCollecting = 0; mEmitting = 0;
      end else begin
        for (int i = 0; i < NN; i++) if (v[i] && !mMask[i]) mLane[i] = d[i*DW +: DW];
        mMask = mMask | v; mAge++; mEmitting = 0;
      end
    end
    // A frame finishing here is released in the emit cycle; collecting resets below
    if (mEmitting) begin
      for (int i = 0; i < NN; i++) mOut[i*DW +: DW] = mLane[i];
    end
  endtask

  task automatic compareAll();
    check("outValid", NN*DW'(outValid), NN*DW'(mEmitting));
    check("outData", outData, mOut);
    check("capturedMask", NN*DW'(capturedMask), NN*DW'(mMask));
    check("errDup", NN*DW'(errDup), NN*DW'(mDup));
    check("errTimeout", NN*DW'(errTimeout), NN*DW'(mTo));
    check("busy", NN*DW'(busy), NN*DW'(mCollecting || mEmitting));
    if (outValid) validPulses++;
    if (errDup) dupPulses++;
    if (errTimeout) toPulses++;
  endtask

  // One clock: drive on the falling edge, advance the model at the rising edge, compare just after
  task automatic step(input logic [NN-1:0] v, input logic [NN*DW-1:0] d);
    @(negedge clk);
    neuronValid = v;
    neuronData  = d;
    @(posedge clk);
    if (mEmitting) begin mEmitting = 0; mMask = '0; end
    modelStep(v, d);
    #1;
    compareAll();
  endtask

  function automatic logic [NN*DW-1:0] mkData(input logic [DW-1:0] base);
    logic [NN*DW-1:0] r;
    for (int i = 0; i < NN; i++) r[i*DW +: DW] = base + DW'(i);
    return r;
  endfunction

  function automatic logic [NN*DW-1:0] rndData();
    logic [NN*DW-1:0] r;
    for (int i = 0; i < NN; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  initial begin
    logic [NN*DW-1:0] d;
    logic [NN-1:0] v;
    int k;
    modelReset();
    validPulses = 0; dupPulses = 0; toPulses = 0;
    repeat (3) @(posedge clk);
    #1;
    compareAll();
    check("reset outData literal", outData, '0);
    @(negedge clk);
    rst = 1'b1;

    // T1 in-order fill
    d = mkData(16'h0100);
    validPulses = 0;
    for (int i = 0; i < NN; i++) begin
      v = '0; v[i] = 1'b1;
      step(v, d);
    end
    check("T1 outValid after lane 9", NN*DW'(outValid), NN*DW'(1));
    check("T1 single pulse", NN*DW'(validPulses), NN*DW'(1));
    check("T1 lane 0", NN*DW'(outData[0 +: DW]), NN*DW'(16'h0100));
    check("T1 lane 9", NN*DW'(outData[9*DW +: DW]), NN*DW'(16'h0109));
    step('0, '0);
    check("T1 busy cleared", NN*DW'(busy), NN*DW'(0));

    // T2 all lanes together, three frames back to back
    validPulses = 0; dupPulses = 0;
    for (int f = 0; f < 3; f++) begin
      d = mkData(DW'(16'h2000 + 16'h0100 * f));
      step('1, d);
      check("T2 outData literal", outData, d);
    end
    check("T2 three pulses", NN*DW'(validPulses), NN*DW'(3));
    check("T2 no dup", NN*DW'(dupPulses), NN*DW'(0));
    step('0, '0);

    // T3 duplicate on lane 4 keeps the first value
    dupPulses = 0;
    d = '0; d[4*DW +: DW] = 16'hAAAA;
    step(10'h010, d);
    d[4*DW +: DW] = 16'hBBBB;
    step(10'h010, d);
    check("T3 errDup pulse", NN*DW'(errDup), NN*DW'(1));
    step(10'h3EF, d);
    check("T3 lane 4 first value", NN*DW'(outData[4*DW +: DW]), NN*DW'(16'hAAAA));
    check("T3 single dup", NN*DW'(dupPulses), NN*DW'(1));
    step('0, '0);

    // T4 timeout: 16 edges after the capture edge
    validPulses = 0; toPulses = 0;
    step(10'h1FF, mkData(16'h4000));
    for (int i = 0; i < TO - 1; i++) step('0, '0);
    check("T4 no early timeout", NN*DW'(toPulses), NN*DW'(0));
    step('0, '0);
    check("T4 errTimeout", NN*DW'(errTimeout), NN*DW'(1));
    check("T4 mask cleared", NN*DW'(capturedMask), NN*DW'(0));
    check("T4 no outValid", NN*DW'(validPulses), NN*DW'(0));
    d = mkData(16'h4100);
    step('1, d);
    check("T4 follow-up frame", outData, d);

    // T5 reset pulse mid-frame
    step(10'h01F, mkData(16'h5000));
    @(negedge clk);
    neuronValid = '0;
    #2 rst = 1'b0;
    #1;
    modelReset();
    check("T5 mask zero", NN*DW'(capturedMask), NN*DW'(0));
    check("T5 busy zero", NN*DW'(busy), NN*DW'(0));
    check("T5 outData zero", outData, '0);
    #1 rst = 1'b1;
    d = mkData(16'h5100);
    step('1, d);
    check("T5 frame after reset", outData, d);

    // T6 completion on the timeout cycle
    toPulses = 0;
    step(10'h1FF, mkData(16'h6000));
    for (int i = 0; i < TO - 1; i++) step('0, '0);
    d = mkData(16'h6000);
    step(10'h200, d);
    check("T6 outValid at edge", NN*DW'(outValid), NN*DW'(1));
    check("T6 no timeout", NN*DW'(toPulses), NN*DW'(0));
    check("T6 outData", outData, d);

    // Random strobes across dense, sparse and quiet phases
    for (int n = 0; n < 3000; n++) begin
      k = (n / 250) % 4;
      v = '0;
      if (k == 0) v = NN'($urandom);
      else if (k == 1) begin
        for (int i = 0; i < NN; i++) v[i] = ($urandom_range(0, 9) == 0);
      end else if (k == 2) begin
        if ($urandom_range(0, 3) == 0) v = '1;
      end else begin
        for (int i = 0; i < NN; i++) v[i] = ($urandom_range(0, 39) == 0);
      end
      step(v, rndData());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
